// File: rtl/adc0809_scan_peak_if.sv
// adc0809_scan_peak_if: converter strobes, control inputs and per-channel result buses of the scanner
interface adc0809_scan_peak_if #(parameter int NUM_CH = 4, parameter int DW = 8);
   logic                 sample_en;
   logic                 peak_clr;
   logic                 eoc;
   logic [DW-1:0]        adc_data;
   logic                 adc_clock;
   logic                 start;
   logic                 ale;
   logic                 oe;
   logic [2:0]           address;
   logic [NUM_CH*DW-1:0] value_bus;
   logic [NUM_CH*DW-1:0] max_bus;
   logic [NUM_CH*DW-1:0] min_bus;
   logic                 sample_valid;
   logic [2:0]           sample_ch;
   logic                 eoc_timeout;
   modport master (
      input  sample_en, peak_clr, eoc, adc_data,
      output adc_clock, start, ale, oe, address, value_bus, max_bus, min_bus,
             sample_valid, sample_ch, eoc_timeout
   );
   modport slave (
      output sample_en, peak_clr, eoc, adc_data,
      input  adc_clock, start, ale, oe, address, value_bus, max_bus, min_bus,
             sample_valid, sample_ch, eoc_timeout
   );
endinterface

// File: rtl/adc0809_scan_peak.sv
// adc0809_scan_peak: round-robin ADC0809 scanner with per-channel latest sample and peak hold.
// Define MIN_HOLD_EN to add per-channel min-hold registers (otherwise min_bus is all-ones).
module adc0809_scan_peak #(
   parameter int NUM_CH  = 4,
   parameter int DW      = 8,
   parameter int ADC_DIV = 25,
   parameter int PH_CYC  = 2,
   parameter int EOC_TO  = 4095
) (
   input logic                 clock,
   input logic                 reset,
   adc0809_scan_peak_if.master bus
);
   localparam int CW = $clog2(EOC_TO + ADC_DIV + PH_CYC + 2);
   typedef enum logic [2:0] {IDLE, ADDR, ALE, START, WAIT_LO, WAIT_HI, READ, STORE} state_t;
   state_t               r_state, w_nxt;
   logic [CW-1:0]        r_cnt, r_div;
   logic [2:0]           r_ch, r_sch;
   logic [1:0]           r_eoc_s;
   logic [DW-1:0]        r_data;
   logic                 r_adc_clk, r_start, r_ale, r_oe, r_sv, r_to;
   logic [NUM_CH*DW-1:0] r_val, r_max;
   logic [NUM_CH-1:0]    w_st;
   logic                 w_last, w_tmo, w_adv, w_eoc, w_div;
   assign w_eoc  = r_eoc_s[1];
   assign w_last = r_cnt == CW'(PH_CYC - 1);
   assign w_div  = r_div == CW'(ADC_DIV - 1);
   assign w_adv  = r_state == STORE || w_tmo;
   always_comb begin
      w_nxt = r_state;
      w_tmo = 1'b0;
      case (r_state)
         IDLE:    w_nxt = bus.sample_en ? ADDR : IDLE;
         ADDR:    w_nxt = w_last ? ALE : ADDR;
         ALE:     w_nxt = w_last ? START : ALE;
         START:   w_nxt = w_last ? WAIT_LO : START;
         WAIT_LO: begin
            w_tmo = w_eoc && r_cnt == CW'(EOC_TO - 1);
            w_nxt = !w_eoc ? WAIT_HI : w_tmo ? (bus.sample_en ? ADDR : IDLE) : WAIT_LO;
         end
         WAIT_HI: begin
            w_tmo = !w_eoc && r_cnt == CW'(EOC_TO - 1);
            w_nxt = w_eoc ? READ : w_tmo ? (bus.sample_en ? ADDR : IDLE) : WAIT_HI;
         end
         READ:    w_nxt = w_last ? STORE : READ;
         default: w_nxt = bus.sample_en ? ADDR : IDLE;
      endcase
   end
   always_comb begin
      w_st = '0;
      for (int k = 0; k < NUM_CH; k++) w_st[k] = r_state == STORE && r_ch == 3'(k);
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_div     <= '0;
         r_adc_clk <= 1'b0;
         r_eoc_s   <= '0;
         r_ale     <= 1'b0;
         r_start   <= 1'b0;
         r_oe      <= 1'b0;
         r_data    <= '0;
         r_sv      <= 1'b0;
         r_sch     <= '0;
         r_ch      <= '0;
         r_to      <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_cnt     <= (w_nxt != r_state || r_state == IDLE) ? '0 : r_cnt + CW'(1);
         r_div     <= w_div ? '0 : r_div + CW'(1);
         r_adc_clk <= r_adc_clk ^ w_div;
         r_eoc_s   <= {r_eoc_s[0], bus.eoc};
         r_ale     <= w_nxt == ALE || w_nxt == START;
         r_start   <= w_nxt == START;
         r_oe      <= w_nxt == READ;
         if (r_state == READ && w_last) r_data <= bus.adc_data;
         r_sv      <= r_state == STORE;
         if (r_state == STORE) r_sch <= r_ch;
         if (w_adv) r_ch <= (r_ch == 3'(NUM_CH - 1)) ? '0 : r_ch + 3'd1;
         r_to      <= w_tmo | (r_to & ~bus.peak_clr);
      end
   end
   // a STORE coinciding with peak_clr seeds the cleared hold with the new sample
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_val <= '0;
         r_max <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_st[k]) r_val[k*DW +: DW] <= r_data;
            if (w_st[k] && (bus.peak_clr || r_data > r_max[k*DW +: DW])) r_max[k*DW +: DW] <= r_data;
            else if (bus.peak_clr) r_max[k*DW +: DW] <= '0;
         end
      end
   end
`ifdef MIN_HOLD_EN
   logic [NUM_CH*DW-1:0] r_min;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_min <= '1;
      else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_st[k] && (bus.peak_clr || r_data < r_min[k*DW +: DW])) r_min[k*DW +: DW] <= r_data;
            else if (bus.peak_clr) r_min[k*DW +: DW] <= '1;
         end
      end
   end
   assign bus.min_bus = r_min;
`else
   assign bus.min_bus = '1;
`endif
   assign bus.adc_clock    = r_adc_clk;
   assign bus.start        = r_start;
   assign bus.ale          = r_ale;
   assign bus.oe           = r_oe;
   assign bus.address      = r_ch;
   assign bus.value_bus    = r_val;
   assign bus.max_bus      = r_max;
   assign bus.sample_valid = r_sv;
   assign bus.sample_ch    = r_sch;
   assign bus.eoc_timeout  = r_to;
endmodule

// File: tb/tb_adc0809_scan_peak.sv
// tb_adc0809_scan_peak: random ADC0809 converter model plus per-channel hold scoreboard for adc0809_scan_peak
module tb_adc0809_scan_peak;
   localparam int NUM_CH = 4, DW = 8, ADC_DIV = 3, PH_CYC = 2, EOC_TO = 16;
   typedef struct {int ch; logic [DW-1:0] d;} conv_t;
   logic clk = 1'b0, rst_n = 1'b0, sample_en = 1'b0, peak_clr = 1'b0, eoc = 1'b1;
   logic pclr_edge = 1'b0, cv_st_d = 1'b0;
   logic [DW-1:0] cur_data = '0, cv_d;
   logic [2:0] cv_addr = '0;
   int cur_ch = 8, cv_ch, exp_next_ch = 0, stuck_ch = 8;
   int n_chk = 0, n_fail = 0, n_samp = 0, n_starts = 0, base, sbase, lim, run;
   int n_ch[NUM_CH];
   logic a;
   logic [DW-1:0] m_val[NUM_CH], m_max[NUM_CH], m_min[NUM_CH];
   logic [NUM_CH*DW-1:0] pv, pm, pn;
   conv_t conv_q[$], force_q[$], sb_e;

   adc0809_scan_peak_if #(.NUM_CH(NUM_CH), .DW(DW)) bus();
   assign bus.sample_en = sample_en;
   assign bus.peak_clr  = peak_clr;
   assign bus.eoc       = eoc;
   assign bus.adc_data  = bus.oe ? cur_data : ~cur_data;

   adc0809_scan_peak #(.NUM_CH(NUM_CH), .DW(DW), .ADC_DIV(ADC_DIV), .PH_CYC(PH_CYC), .EOC_TO(EOC_TO)) dut (
      .clock(clk),
      .reset(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state();
      check("rst_start", bus.start, 0);
      check("rst_ale", bus.ale, 0);
      check("rst_oe", bus.oe, 0);
      check("rst_address", bus.address, 0);
      check("rst_adc_clock", bus.adc_clock, 0);
      check("rst_sample_valid", bus.sample_valid, 0);
      check("rst_eoc_timeout", bus.eoc_timeout, 0);
      check("rst_value_bus", bus.value_bus, 0);
      check("rst_max_bus", bus.max_bus, 0);
      check("rst_min_bus", bus.min_bus, {NUM_CH*DW{1'b1}});
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         m_val[k] = '0;
         m_max[k] = '0;
         m_min[k] = '1;
         n_ch[k]  = 0;
      end
      conv_q.delete();
      force_q.delete();
      exp_next_ch = 0;
      cur_ch = 8;
   endtask

   task automatic wait_samples(input int n);
      int l = 0;
      while (n_samp < n && l < 4000) begin
         @(negedge clk);
         l++;
      end
      if (n_samp < n) check("wait_samples", n_samp, n);
   endtask

   // converter: a start rising edge begins a conversion on the expected round-robin channel
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.start && !cv_st_d) begin
            n_starts++;
            cv_addr = bus.address;
            check("start_address", bus.address, exp_next_ch);
            cv_ch = exp_next_ch;
            exp_next_ch = (exp_next_ch + 1) % NUM_CH;
            if (cv_ch == stuck_ch) stuck_ch = 8;
            else begin
               cv_d = DW'($urandom);
               for (int i = 0; i < force_q.size(); i++)
                  if (force_q[i].ch == cv_ch) begin
                     cv_d = force_q[i].d;
                     force_q.delete(i);
                     break;
                  end
               cur_ch = cv_ch;
               cur_data = cv_d;
               conv_q.push_back('{cv_ch, cv_d});
               repeat (2) @(negedge clk);
               eoc = 1'b0;
               repeat ($urandom_range(6, 12)) @(negedge clk);
               eoc = 1'b1;
            end
         end
         cv_st_d = bus.start;
      end
   end

   always @(posedge clk) pclr_edge = peak_clr;

   // scoreboard: holds are cleared by a peak_clr seen at the store edge, then updated by the sample
   always @(negedge clk) begin
      if (rst_n) begin
         if (pclr_edge)
            for (int k = 0; k < NUM_CH; k++) begin
               m_max[k] = '0;
               m_min[k] = '1;
            end
         if (bus.sample_valid) begin
            if (conv_q.size() == 0) check("spurious_sample", conv_q.size(), 1);
            else begin
               sb_e = conv_q.pop_front();
               check("sample_ch", bus.sample_ch, sb_e.ch);
               m_val[sb_e.ch] = sb_e.d;
               if (sb_e.d > m_max[sb_e.ch]) m_max[sb_e.ch] = sb_e.d;
               if (sb_e.d < m_min[sb_e.ch]) m_min[sb_e.ch] = sb_e.d;
               n_samp++;
               n_ch[sb_e.ch]++;
               for (int k = 0; k < NUM_CH; k++) begin
                  pv[k*DW +: DW] = m_val[k];
                  pm[k*DW +: DW] = m_max[k];
                  pn[k*DW +: DW] = m_min[k];
               end
               check("value_bus", bus.value_bus, pv);
               check("max_bus", bus.max_bus, pm);
`ifdef MIN_HOLD_EN
               check("min_bus", bus.min_bus, pn);
`else
               check("min_bus", bus.min_bus, {NUM_CH*DW{1'b1}});
`endif
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state();
      rst_n = 1'b1;
      // adc_clock runs freely in IDLE
      a = bus.adc_clock;
      lim = 0;
      while (bus.adc_clock == a && lim < 20) begin
         @(negedge clk);
         lim++;
      end
      a = bus.adc_clock;
      run = 0;
      while (bus.adc_clock == a && run < 20) begin
         @(negedge clk);
         run++;
      end
      check("adc_clock_half_period", run, ADC_DIV);
      // scan
      for (int k = 0; k < NUM_CH; k++) force_q.push_back('{k, DW'(8'h10 + k)});
      sample_en = 1'b1;
      wait_samples(4);
      check("scan_value", bus.value_bus, 32'h13121110);
      check("scan_max", bus.max_bus, 32'h13121110);
      wait_samples(5);
      // random data with random peak clears
      repeat (600) begin
         @(negedge clk);
         peak_clr = $urandom_range(0, 29) == 0;
      end
      @(negedge clk);
      peak_clr = 1'b0;
      // peak hold on ch1
      force_q.push_back('{1, 8'h40});
      force_q.push_back('{1, 8'h90});
      force_q.push_back('{1, 8'h20});
      lim = 0;
      while (!(cur_ch == 1 && cur_data == 8'h40) && lim < 2000) begin
         @(negedge clk);
         lim++;
      end
      peak_clr = 1'b1;
      @(negedge clk);
      peak_clr = 1'b0;
      lim = 0;
      while (!(force_q.size() == 0 && cur_ch == 2) && lim < 4000) begin
         @(negedge clk);
         lim++;
      end
      check("peak_value1", bus.value_bus[15:8], 8'h20);
      check("peak_max1", bus.max_bus[15:8], 8'h90);
`ifdef MIN_HOLD_EN
      check("peak_min1", bus.min_bus[15:8], 8'h20);
`endif
      // clear coinciding with the store of ch2
      force_q.push_back('{2, 8'h05});
      lim = 0;
      while (!(bus.oe && cur_ch == 2 && cur_data == 8'h05) && lim < 2000) begin
         @(negedge clk);
         lim++;
      end
      lim = 0;
      while (bus.oe && lim < 20) begin
         @(negedge clk);
         lim++;
      end
      peak_clr = 1'b1;
      @(negedge clk);
      peak_clr = 1'b0;
      check("clr_sample_valid", bus.sample_valid, 1);
      check("clr_sample_ch", bus.sample_ch, 2);
      check("clr_max_bus", bus.max_bus, 32'h00050000);
      // EOC timeout on ch3
      stuck_ch = 3;
      lim = 0;
      while (!bus.eoc_timeout && lim < 2000) begin
         @(negedge clk);
         lim++;
      end
      check("timeout_flag", bus.eoc_timeout, 1);
      check("timeout_value3", bus.value_bus[31:24], m_val[3]);
      base = n_starts;
      lim = 0;
      while (n_starts == base && lim < 200) begin
         @(negedge clk);
         lim++;
      end
      check("timeout_next_addr", cv_addr, 0);
      peak_clr = 1'b1;
      @(negedge clk);
      peak_clr = 1'b0;
      @(negedge clk);
      check("timeout_cleared", bus.eoc_timeout, 0);
      // stop during WAIT_HI
      lim = 0;
      while (eoc && lim < 2000) begin
         @(negedge clk);
         lim++;
      end
      repeat (4) @(negedge clk);
      sample_en = 1'b0;
      base = n_samp;
      sbase = n_starts;
      repeat (150) @(negedge clk);
      check("stop_samples", n_samp - base, 1);
      check("stop_starts", n_starts - sbase, 0);
      check("stop_strobes", {bus.start, bus.ale, bus.oe}, 0);
      // asynchronous reset mid-READ
      sample_en = 1'b1;
      lim = 0;
      while (!bus.oe && lim < 2000) begin
         @(negedge clk);
         lim++;
      end
      check("read_reached", bus.oe, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_state();
      repeat (30) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      wait_samples(n_samp + 6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
